// File: rtl/uart_cmd_rx_pkg.sv
// Shared definitions for the UART command receive front end and the backend dispatcher.
// Holds the frame FSM encoding, default framing constants and the checksum helper.
package uart_cmd_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_CMD  = 3'd1,
        ST_GET_LEN  = 3'd2,
        ST_GET_DATA = 3'd3,
        ST_GET_CHK  = 3'd4
    } state_t;

    localparam logic [7:0] HDR_DEFAULT     = 8'hA5;
    localparam int         MAX_LEN_DEFAULT = 16;
    localparam int         TIMEOUT_DEFAULT = 1000;

    // Command codes understood by the backend dispatcher.
    localparam logic [7:0] CMD_SEND_FIFO   = 8'h01;

    // Running frame checksum: XOR of CMD, LEN and every payload byte.
    function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] b);
        return chk ^ b;
    endfunction

endpackage

// File: rtl/uart_cmd_rx_timeout.sv
// Inter-byte idle watchdog for an open frame; expire is asserted on the cycle the
// saturating counter sits at TIMEOUT-1 with no byte arriving.
module frame_timeout #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic rx_valid,
    output logic expire
);

    localparam int            CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_r;

    // Idle-cycle counter: cleared by any byte or while idle, holds at LIMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (!active || rx_valid) begin
            cnt_r <= '0;
        end else if (cnt_r != LIMIT) begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // A byte on the limit cycle wins over the timeout.
    assign expire = active && !rx_valid && (cnt_r == LIMIT);

endmodule

// File: rtl/uart_cmd_rx.sv
// Frames UART bytes into HDR/CMD/LEN/payload/CHK packets, streams payload into the TX
// data FIFO and publishes each checksum-validated command byte to the dispatcher.
module uart_cmd_rx
    import uart_cmd_rx_pkg::*;
#(
    parameter logic [7:0] HDR     = HDR_DEFAULT,
    parameter int         MAX_LEN = MAX_LEN_DEFAULT,
    parameter int         TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       fifo_full,
    output logic       fifo_wr_en,
    output logic [7:0] fifo_wdata,
    output logic [7:0] cmd,
    output logic       cmd_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t     state_r,  state_nxt_s;
    logic [7:0] cmd_tmp_r, cmd_tmp_nxt_s;
    logic [7:0] chk_r,     chk_nxt_s;
    logic [7:0] count_r,   count_nxt_s;
    logic       ovf_r,     ovf_nxt_s;

    logic       wr_en_r,     wr_en_nxt_s;
    logic [7:0] wdata_r,     wdata_nxt_s;
    logic [7:0] cmd_r,       cmd_nxt_s;
    logic       cmd_valid_r, cmd_valid_nxt_s;
    logic       frame_err_r, frame_err_nxt_s;
    logic       busy_r;
    logic       timeout_s;

    frame_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .active   (state_r != ST_IDLE),
        .rx_valid (rx_valid),
        .expire   (timeout_s)
    );

    // Frame FSM next-state and next-output decode.
    always_comb begin
        state_nxt_s     = state_r;
        cmd_tmp_nxt_s   = cmd_tmp_r;
        chk_nxt_s       = chk_r;
        count_nxt_s     = count_r;
        ovf_nxt_s       = ovf_r;
        wr_en_nxt_s     = 1'b0;
        wdata_nxt_s     = wdata_r;
        cmd_nxt_s       = cmd_r;
        cmd_valid_nxt_s = 1'b0;
        frame_err_nxt_s = 1'b0;

        if (timeout_s) begin
            state_nxt_s     = ST_IDLE;
            ovf_nxt_s       = 1'b0;
            frame_err_nxt_s = 1'b1;
        end else if (rx_valid) begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_data == HDR) begin
                        state_nxt_s = ST_GET_CMD;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_GET_CMD: begin
                    cmd_tmp_nxt_s = rx_data;
                    chk_nxt_s     = rx_data;
                    state_nxt_s   = ST_GET_LEN;
                end
                ST_GET_LEN: begin
                    chk_nxt_s = chk_update(chk_r, rx_data);
                    if (rx_data == 8'h00) begin
                        state_nxt_s = ST_GET_CHK;
                    end else if (rx_data > MAX_LEN_B) begin
                        frame_err_nxt_s = 1'b1;
                        state_nxt_s     = ST_IDLE;
                    end else begin
                        count_nxt_s = rx_data;
                        state_nxt_s = ST_GET_DATA;
                    end
                end
                ST_GET_DATA: begin
                    chk_nxt_s   = chk_update(chk_r, rx_data);
                    count_nxt_s = count_r - 8'd1;
                    // A dropped byte poisons the frame so the command is never issued.
                    if (!fifo_full) begin
                        wr_en_nxt_s = 1'b1;
                        wdata_nxt_s = rx_data;
                    end else begin
                        ovf_nxt_s = 1'b1;
                    end
                    if (count_r == 8'd1) begin
                        state_nxt_s = ST_GET_CHK;
                    end else begin
                        state_nxt_s = ST_GET_DATA;
                    end
                end
                ST_GET_CHK: begin
                    if ((rx_data == chk_r) && !ovf_r) begin
                        cmd_nxt_s       = cmd_tmp_r;
                        cmd_valid_nxt_s = 1'b1;
                    end else begin
                        frame_err_nxt_s = 1'b1;
                    end
                    ovf_nxt_s   = 1'b0;
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    ovf_nxt_s   = 1'b0;
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, frame context and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cmd_tmp_r   <= 8'h00;
            chk_r       <= 8'h00;
            count_r     <= 8'h00;
            ovf_r       <= 1'b0;
            wr_en_r     <= 1'b0;
            wdata_r     <= 8'h00;
            cmd_r       <= 8'h00;
            cmd_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cmd_tmp_r   <= cmd_tmp_nxt_s;
            chk_r       <= chk_nxt_s;
            count_r     <= count_nxt_s;
            ovf_r       <= ovf_nxt_s;
            wr_en_r     <= wr_en_nxt_s;
            wdata_r     <= wdata_nxt_s;
            cmd_r       <= cmd_nxt_s;
            cmd_valid_r <= cmd_valid_nxt_s;
            frame_err_r <= frame_err_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
        end
    end

    assign fifo_wr_en = wr_en_r;
    assign fifo_wdata = wdata_r;
    assign cmd        = cmd_r;
    assign cmd_valid  = cmd_valid_r;
    assign frame_err  = frame_err_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: framing, checksum, FIFO back-pressure, length limit,
// inter-byte timeout and mid-frame reset, with hand-computed expectations.
module tb_uart_cmd_rx;
    import uart_cmd_rx_pkg::*;

    localparam int TO = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       fifo_full;
    logic       fifo_wr_en;
    logic [7:0] fifo_wdata;
    logic [7:0] cmd;
    logic       cmd_valid;
    logic       frame_err;
    logic       busy;

    always #5 clk = ~clk;

    uart_cmd_rx #(
        .HDR     (8'hA5),
        .MAX_LEN (16),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_wdata (fifo_wdata),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int cv_cnt   = 0;
    int fe_cnt   = 0;
    int cv0, fe0;
    logic [7:0] wq[$];
    logic [7:0] fq[$];
    logic [7:0] xq[$];
    logic [7:0] ck;

    // Pulse monitor, sampled 2 ns after the rising edge.
    always @(posedge clk) begin
        #2;
        if (fifo_wr_en) begin
            wr_cnt++;
            wq.push_back(fifo_wdata);
        end
        if (cmd_valid) cv_cnt++;
        if (frame_err) fe_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_list(input logic [7:0] bl[$]);
        foreach (bl[i]) send_byte(bl[i]);
    endtask

    task automatic start_test();
        @(negedge clk);
        wq.delete();
        cv0 = cv_cnt;
        fe0 = fe_cnt;
    endtask

    task automatic check_writes(input string tag, input logic [7:0] exp[$]);
        check_eq({tag, "_nwr"}, wq.size(), exp.size());
        if (wq.size() == exp.size()) begin
            foreach (exp[i]) check_eq({tag, "_wdata"}, wq[i], exp[i]);
        end
    endtask

    initial begin
        rst       = 1'b1;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        fifo_full = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_wr_en", fifo_wr_en, 0);
        check_eq("rst_wdata", fifo_wdata, 0);
        check_eq("rst_cmd", cmd, 0);
        check_eq("rst_cmd_valid", cmd_valid, 0);
        check_eq("rst_frame_err", frame_err, 0);
        check_eq("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Good frame
        start_test();
        send_byte(8'hA5);
        check_eq("good_busy_hdr", busy, 1);
        fq = {8'h01, 8'h02, 8'h11};
        send_list(fq);
        check_eq("good_wr_latency", fifo_wr_en, 1);
        check_eq("good_wdata_now", fifo_wdata, 8'h11);
        fq = {8'h22, 8'h30};
        send_list(fq);
        check_eq("good_cmd_valid", cmd_valid, 1);
        check_eq("good_cmd", cmd, CMD_SEND_FIFO);
        check_eq("good_busy_end", busy, 0);
        @(negedge clk);
        check_eq("good_cmd_valid_pulse", cmd_valid, 0);
        xq = {8'h11, 8'h22};
        check_writes("good", xq);
        check_eq("good_ncv", cv_cnt - cv0, 1);
        check_eq("good_nfe", fe_cnt - fe0, 0);

        // HDR value inside payload is plain data: 7E^01^A5 = DA
        start_test();
        fq = {8'hA5, 8'h7E, 8'h01, 8'hA5, 8'hDA};
        send_list(fq);
        check_eq("hdrdata_cmd", cmd, 8'h7E);
        xq = {8'hA5};
        check_writes("hdrdata", xq);
        check_eq("hdrdata_ncv", cv_cnt - cv0, 1);

        // Bad checksum
        start_test();
        fq = {8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h31};
        send_list(fq);
        check_eq("badchk_frame_err", frame_err, 1);
        check_eq("badchk_cmd_held", cmd, 8'h7E);
        xq = {8'h11, 8'h22};
        check_writes("badchk", xq);
        check_eq("badchk_ncv", cv_cnt - cv0, 0);
        check_eq("badchk_nfe", fe_cnt - fe0, 1);

        // Leading noise then zero-length frame
        start_test();
        fq = {8'h00, 8'hFF};
        send_list(fq);
        check_eq("noise_busy", busy, 0);
        fq = {8'hA5, 8'h01, 8'h00, 8'h01};
        send_list(fq);
        check_eq("zlen_cmd", cmd, 8'h01);
        xq = {};
        check_writes("zlen", xq);
        check_eq("zlen_ncv", cv_cnt - cv0, 1);
        check_eq("zlen_nfe", fe_cnt - fe0, 0);

        // FIFO full during second payload byte
        start_test();
        fq = {8'hA5, 8'h01, 8'h02, 8'h11};
        send_list(fq);
        fifo_full = 1'b1;
        send_byte(8'h22);
        fifo_full = 1'b0;
        send_byte(8'h30);
        check_eq("full_frame_err", frame_err, 1);
        xq = {8'h11};
        check_writes("full", xq);
        check_eq("full_ncv", cv_cnt - cv0, 0);
        check_eq("full_nfe", fe_cnt - fe0, 1);

        // LEN = MAX_LEN accepted: payload 00..0F XORs to 0, so CHK = 02^10 = 12
        start_test();
        fq = {8'hA5, 8'h02, 8'h10};
        send_list(fq);
        xq = {};
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i));
            xq.push_back(8'(i));
        end
        send_byte(8'h12);
        check_eq("maxlen_cmd", cmd, 8'h02);
        check_writes("maxlen", xq);
        check_eq("maxlen_ncv", cv_cnt - cv0, 1);

        // LEN = 17 rejected one cycle after LEN byte
        start_test();
        fq = {8'hA5, 8'h01, 8'h11};
        send_list(fq);
        check_eq("len17_frame_err", frame_err, 1);
        check_eq("len17_busy", busy, 0);
        @(negedge clk);
        check_eq("len17_err_pulse", frame_err, 0);
        check_eq("len17_nfe", fe_cnt - fe0, 1);

        // Silence after CMD: error exactly TIMEOUT cycles after last byte
        start_test();
        fq = {8'hA5, 8'h01};
        send_list(fq);
        repeat (TO - 1) @(negedge clk);
        check_eq("to_not_yet", frame_err, 0);
        check_eq("to_busy_before", busy, 1);
        @(negedge clk);
        check_eq("to_frame_err", frame_err, 1);
        check_eq("to_busy_after", busy, 0);
        check_eq("to_nfe", fe_cnt - fe0, 1);

        // Byte on the timeout cycle wins
        start_test();
        fq = {8'hA5, 8'h01};
        send_list(fq);
        repeat (TO - 2) @(negedge clk);
        send_byte(8'h00);
        check_eq("to_edge_no_err", frame_err, 0);
        check_eq("to_edge_busy", busy, 1);
        send_byte(8'h01);
        check_eq("to_edge_cmd_valid", cmd_valid, 1);
        check_eq("to_edge_nfe", fe_cnt - fe0, 0);

        // Reset mid-frame
        start_test();
        fq = {8'hA5, 8'h01, 8'h02, 8'h11};
        send_list(fq);
        check_eq("mid_wr_before_rst", fifo_wr_en, 1);
        #1 rst = 1'b1;
        #1;
        check_eq("mid_rst_outs", {fifo_wr_en, fifo_wdata, cmd, cmd_valid, frame_err, busy}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        start_test();
        fq = {8'hA5, 8'h01, 8'h00, 8'h01};
        send_list(fq);
        check_eq("post_rst_cmd_valid", cmd_valid, 1);
        check_eq("post_rst_cmd", cmd, 8'h01);
        check_eq("post_rst_nfe", fe_cnt - fe0, 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
